time_edit_ctrl: RTL and testbench

Time-editing controller that sits directly upstream of the hour-digit VGA renderer. It supplies the three BCD time bytes (hh, mm, ss), the program-mode flag and the edit cursor that the renderer draws. In normal mode it mirrors the time read from the RTC. In program mode it lets the user move a cursor and increment or decrement fields from debounced buttons, then hands the edited time to the RTC write path through a req/ack handshake.

---
 rtl/time_edit_ctrl.sv | 148 ++++++++++++++
 tb/tb_time_edit_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/time_edit_ctrl.sv
// Time-editing controller: mirrors RTC time in IDLE, lets the user edit
// hh/mm/ss with a cursor in EDIT, and hands the result to the RTC writer
// through a wr_req/wr_ack handshake in COMMIT.
module time_edit_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_prog,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic [7:0] rtc_hour,
   input  logic [7:0] rtc_min,
   input  logic [7:0] rtc_sec,
   input  logic       rtc_valid,
   input  logic       wr_ack,
   output logic [7:0] hour_out1,
   output logic [7:0] hour_out2,
   output logic [7:0] hour_out3,
   output logic       programar_on,
   output logic [3:0] direccion_actual_pantalla,
   output logic       wr_req
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EDIT   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t     state_q;
   logic [7:0] hh_q, mm_q, ss_q;
   logic [1:0] cur_q;
   logic       prog_on_q, wr_req_q;

   // Button order: {prog, left, right, up, down}
   logic [4:0] btn_d, btn_q, edge_d;
   logic       e_prog, e_left, e_right, e_up, e_down;

   // BCD increment with wrap at max; any invalid value restarts at 00.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
      if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v >= max)
         return '0;
      else if (v[3:0] == 4'd9)
         return {v[7:4] + 4'd1, 4'd0};
      else
         return {v[7:4], v[3:0] + 4'd1};
   endfunction

   // BCD decrement with wrap to max; any invalid value jumps to max.
   function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
      if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v > max || v == 8'h00)
         return max;
      else if (v[3:0] == 4'd0)
         return {v[7:4] - 4'd1, 4'd9};
      else
         return {v[7:4], v[3:0] - 4'd1};
   endfunction

   // Rising-edge detection against the previous sampled button levels.
   always_comb begin
      btn_d   = {btn_prog, btn_left, btn_right, btn_up, btn_down};
      edge_d  = btn_d & ~btn_q;
      e_prog  = edge_d[4];
      e_left  = edge_d[3];
      e_right = edge_d[2];
      e_up    = edge_d[1];
      e_down  = edge_d[0];
   end

   // Mode FSM with registered time fields, cursor and handshake flags.
   always_ff @(posedge clk) begin
      // Loading btn_q during reset keeps a button held through reset silent.
      btn_q <= btn_d;
      if (reset) begin
         state_q   <= IDLE;
         hh_q      <= '0;
         mm_q      <= '0;
         ss_q      <= '0;
         cur_q     <= '0;
         prog_on_q <= 1'b0;
         wr_req_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               cur_q     <= '0;
               prog_on_q <= 1'b0;
               wr_req_q  <= 1'b0;
               if (rtc_valid) begin
                  hh_q <= rtc_hour;
                  mm_q <= rtc_min;
                  ss_q <= rtc_sec;
               end
               if (e_prog) begin
                  state_q   <= EDIT;
                  prog_on_q <= 1'b1;
               end
            end
            EDIT: begin
               if (e_prog) begin
                  state_q  <= COMMIT;
                  wr_req_q <= 1'b1;
               end else if (e_up || e_down) begin
                  // Simultaneous up and down cancel but still block cursor moves.
                  if (e_up && !e_down) begin
                     case (cur_q)
                        2'd0:    hh_q <= bcd_inc(hh_q, 8'h23);
                        2'd1:    mm_q <= bcd_inc(mm_q, 8'h59);
                        default: ss_q <= bcd_inc(ss_q, 8'h59);
                     endcase
                  end else if (e_down && !e_up) begin
                     case (cur_q)
                        2'd0:    hh_q <= bcd_dec(hh_q, 8'h23);
                        2'd1:    mm_q <= bcd_dec(mm_q, 8'h59);
                        default: ss_q <= bcd_dec(ss_q, 8'h59);
                     endcase
                  end
               end else if (e_right && !e_left) begin
                  cur_q <= (cur_q == 2'd2) ? 2'd0 : cur_q + 2'd1;
               end else if (e_left && !e_right) begin
                  cur_q <= (cur_q == 2'd0) ? 2'd2 : cur_q - 2'd1;
               end
            end
            COMMIT: begin
               if (wr_ack) begin
                  state_q   <= IDLE;
                  wr_req_q  <= 1'b0;
                  prog_on_q <= 1'b0;
                  cur_q     <= '0;
               end
            end
            default: begin
               state_q   <= IDLE;
               prog_on_q <= 1'b0;
               wr_req_q  <= 1'b0;
            end
         endcase
      end
   end

   assign hour_out1                 = hh_q;
   assign hour_out2                 = mm_q;
   assign hour_out3                 = ss_q;
   assign programar_on              = prog_on_q;
   assign wr_req                    = wr_req_q;
   assign direccion_actual_pantalla = {2'b00, cur_q};

endmodule

// File: tb/tb_time_edit_ctrl.sv
// Directed self-checking bench for time_edit_ctrl.
module tb_time_edit_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn_prog, btn_left, btn_right, btn_up, btn_down;
   logic [7:0] rtc_hour, rtc_min, rtc_sec;
   logic       rtc_valid, wr_ack;
   logic [7:0] hour_out1, hour_out2, hour_out3;
   logic       programar_on, wr_req;
   logic [3:0] direccion_actual_pantalla;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   time_edit_ctrl dut (
      .clk                       (clk),
      .reset                     (reset),
      .btn_prog                  (btn_prog),
      .btn_left                  (btn_left),
      .btn_right                 (btn_right),
      .btn_up                    (btn_up),
      .btn_down                  (btn_down),
      .rtc_hour                  (rtc_hour),
      .rtc_min                   (rtc_min),
      .rtc_sec                   (rtc_sec),
      .rtc_valid                 (rtc_valid),
      .wr_ack                    (wr_ack),
      .hour_out1                 (hour_out1),
      .hour_out2                 (hour_out2),
      .hour_out3                 (hour_out3),
      .programar_on              (programar_on),
      .direccion_actual_pantalla (direccion_actual_pantalla),
      .wr_req                    (wr_req)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Button index: 0 prog, 1 left, 2 right, 3 up, 4 down.
   task automatic press(input int b);
      case (b)
         0: btn_prog  = 1'b1;
         1: btn_left  = 1'b1;
         2: btn_right = 1'b1;
         3: btn_up    = 1'b1;
         default: btn_down = 1'b1;
      endcase
      tick();
      btn_prog = 0; btn_left = 0; btn_right = 0; btn_up = 0; btn_down = 0;
      tick();
   endtask

   task automatic press_n(input int b, input int n);
      for (int i = 0; i < n; i++) press(b);
   endtask

   task automatic rtc_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
      rtc_hour = h; rtc_min = m; rtc_sec = s; rtc_valid = 1'b1;
      tick();
      rtc_valid = 1'b0;
   endtask

   initial begin
      reset = 1; btn_prog = 0; btn_left = 0; btn_right = 0; btn_up = 0; btn_down = 0;
      rtc_hour = 0; rtc_min = 0; rtc_sec = 0; rtc_valid = 0; wr_ack = 0;
      tick(); tick();
      reset = 0;
      check("rst_hh", hour_out1, 8'h00);
      check("rst_mm", hour_out2, 8'h00);
      check("rst_ss", hour_out3, 8'h00);
      check("rst_prog", programar_on, 0);
      check("rst_cur", direccion_actual_pantalla, 0);
      check("rst_wrreq", wr_req, 0);

      // Mirror and enter edit
      rtc_load(8'h12, 8'h34, 8'h56);
      check("mirror_hh", hour_out1, 8'h12);
      check("mirror_mm", hour_out2, 8'h34);
      check("mirror_ss", hour_out3, 8'h56);
      check("mirror_prog", programar_on, 0);
      press(0);
      check("edit_prog", programar_on, 1);
      check("edit_cur", direccion_actual_pantalla, 0);
      check("edit_wrreq", wr_req, 0);

      // Hours wrap
      press_n(4, 13);
      check("hh_down_to_23", hour_out1, 8'h23);
      press(3);
      check("hh_23_up_00", hour_out1, 8'h00);
      press(4);
      check("hh_00_down_23", hour_out1, 8'h23);
      press_n(3, 11);
      check("hh_up_to_10", hour_out1, 8'h10);
      press(4);
      check("hh_10_down_09", hour_out1, 8'h09);
      press(4);
      check("hh_09_down_08", hour_out1, 8'h08);

      // Minutes/seconds wrap and cursor
      press(2);
      check("cur_r1", direccion_actual_pantalla, 1);
      press(2);
      check("cur_r2", direccion_actual_pantalla, 2);
      press_n(3, 3);
      check("ss_up_59", hour_out3, 8'h59);
      press(3);
      check("ss_59_up_00", hour_out3, 8'h00);
      press(1);
      check("cur_l_2to1", direccion_actual_pantalla, 1);
      press_n(4, 34);
      check("mm_down_00", hour_out2, 8'h00);
      press(4);
      check("mm_00_down_59", hour_out2, 8'h59);
      check("hh_untouched", hour_out1, 8'h08);
      press(2);
      check("cur_r_1to2", direccion_actual_pantalla, 2);
      press(2);
      check("cur_r_2to0", direccion_actual_pantalla, 0);
      press(1);
      check("cur_l_0to2", direccion_actual_pantalla, 2);
      press(2);
      check("cur_r_back0", direccion_actual_pantalla, 0);

      // Simultaneous inputs
      btn_up = 1; btn_down = 1; tick(); btn_up = 0; btn_down = 0; tick();
      check("updown_same", hour_out1, 8'h08);
      btn_left = 1; btn_right = 1; tick(); btn_left = 0; btn_right = 0; tick();
      check("leftright_same", direccion_actual_pantalla, 0);
      btn_up = 1; btn_down = 1; btn_right = 1; tick();
      btn_up = 0; btn_down = 0; btn_right = 0; tick();
      check("updown_blocks_cur", direccion_actual_pantalla, 0);
      check("updown_blocks_hh", hour_out1, 8'h08);

      // Held button acts once
      btn_up = 1;
      repeat (10) tick();
      btn_up = 0; tick();
      check("held_up_once", hour_out1, 8'h09);

      // rtc_valid ignored in EDIT
      rtc_load(8'h11, 8'h22, 8'h33);
      check("edit_rtc_hh", hour_out1, 8'h09);
      check("edit_rtc_mm", hour_out2, 8'h59);
      check("edit_rtc_ss", hour_out3, 8'h00);

      // Commit handshake
      press(0);
      check("commit_wrreq", wr_req, 1);
      check("commit_prog", programar_on, 1);
      press(3);
      press(2);
      press(0);
      rtc_load(8'h01, 8'h01, 8'h01);
      check("commit_frozen_hh", hour_out1, 8'h09);
      check("commit_frozen_cur", direccion_actual_pantalla, 0);
      repeat (5) tick();
      check("commit_wait_wrreq", wr_req, 1);
      wr_ack = 1; tick(); wr_ack = 0;
      check("ack_wrreq", wr_req, 0);
      check("ack_prog", programar_on, 0);
      rtc_load(8'h45, 8'h01, 8'h02);
      check("idle_reload_hh", hour_out1, 8'h45);
      check("idle_reload_ss", hour_out3, 8'h02);

      // Reset in COMMIT
      press(0);
      press(0);
      check("commit2_wrreq", wr_req, 1);
      reset = 1; tick(); reset = 0;
      check("rstc_wrreq", wr_req, 0);
      check("rstc_prog", programar_on, 0);
      check("rstc_hh", hour_out1, 8'h00);
      check("rstc_ss", hour_out3, 8'h00);

      // Invalid values
      rtc_load(8'h2A, 8'h7B, 8'h00);
      check("inv_load", hour_out1, 8'h2A);
      press(0);
      press(3);
      check("inv_hh_up_00", hour_out1, 8'h00);
      press(2);
      press(4);
      check("inv_mm_down_59", hour_out2, 8'h59);
      press(0);
      wr_ack = 1; tick(); wr_ack = 0;
      check("inv_exit", programar_on, 0);

      // Button held through reset release
      rtc_load(8'h05, 8'h06, 8'h07);
      btn_prog = 1; btn_up = 1; reset = 1;
      tick(); tick();
      reset = 0;
      tick(); tick();
      check("held_rst_prog", programar_on, 0);
      check("held_rst_hh", hour_out1, 8'h00);
      btn_prog = 0; btn_up = 0; tick();
      press(0);
      check("after_release_prog", programar_on, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
